// File: rtl/sound_sequencer.sv
// sound_sequencer: turns rising edges on the three audio request lines into
// timed tone sequences (1-3 notes, each followed by a silent gap) for the
// board tone generator. A higher- or equal-priority request restarts the
// sequencer; a lower-priority request arriving mid-sequence is ignored.
// state_dbg exposes the FSM state for observation only.
module sound_sequencer #(
    parameter int          MS_DIV       = 31500,
    parameter int          KEY_MS       = 40,
    parameter int          HOLE_NOTE_MS = 80,
    parameter int          BORDER_MS    = 20,
    parameter int          GAP_MS       = 10,
    parameter logic [3:0]  KEY_TONE     = 4'd9,
    parameter logic [3:0]  HOLE_TONE0   = 4'd0,
    parameter logic [3:0]  HOLE_TONE1   = 4'd4,
    parameter logic [3:0]  HOLE_TONE2   = 4'd7,
    parameter logic [3:0]  BORDER_TONE  = 4'd2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       keyAudioRequest,
    input  logic       holeColAudioRequest,
    input  logic       borderColAudioRequest,
    output logic       enableSound,
    output logic [3:0] toneIndex,
    output logic       busy,
    output logic [1:0] state_dbg
);

    // Handshake: the request inputs are plain levels with no ready/ack;
    // only a low-to-high transition starts a sound, a held level does nothing.

    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(MS_DIV - 1);
    localparam logic [7:0] KEY_LIM    = 8'(KEY_MS - 1);
    localparam logic [7:0] HOLE_LIM   = 8'(HOLE_NOTE_MS - 1);
    localparam logic [7:0] BORDER_LIM = 8'(BORDER_MS - 1);
    localparam logic [7:0] GAP_LIM    = 8'(GAP_MS - 1);

    // The ms counter is 8 bits wide, so every duration must fit in 1..255.
    if (MS_DIV < 1 || KEY_MS < 1 || KEY_MS > 255 || HOLE_NOTE_MS < 1 ||
        HOLE_NOTE_MS > 255 || BORDER_MS < 1 || BORDER_MS > 255 ||
        GAP_MS < 1 || GAP_MS > 255) begin : g_param_check
        $error("sound_sequencer: ms parameters must be 1..255 and MS_DIV >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Encoding doubles as priority: larger value wins.
    typedef enum logic [1:0] {
        SND_BORDER = 2'd0,
        SND_HOLE   = 2'd1,
        SND_KEY    = 2'd2
    } snd_t;

    state_t        state, state_n;
    snd_t          snd, snd_n;
    logic [1:0]    note_idx, note_idx_n;
    logic [PW-1:0] presc, presc_n;
    logic [7:0]    ms_cnt, ms_cnt_n;
    logic [3:0]    tone_q, tone_n;
    logic          prev_key, prev_hole, prev_border;

    logic          rise_key, rise_hole, rise_border;
    logic          trig_valid, preempt, tick;
    snd_t          trig_snd;
    logic [7:0]    note_lim;
    logic [1:0]    last_idx;

    function automatic logic [3:0] tone_of(input snd_t s, input logic [1:0] idx);
        logic [3:0] t;
        t = BORDER_TONE;
        case (s)
            SND_KEY:  t = KEY_TONE;
            SND_HOLE: begin
                case (idx)
                    2'd0:    t = HOLE_TONE0;
                    2'd1:    t = HOLE_TONE1;
                    default: t = HOLE_TONE2;
                endcase
            end
            default:  t = BORDER_TONE;
        endcase
        return t;
    endfunction

    // Remember last sampled request levels for rising-edge detection.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_key    <= 1'b0;
            prev_hole   <= 1'b0;
            prev_border <= 1'b0;
        end else begin
            prev_key    <= keyAudioRequest;
            prev_hole   <= holeColAudioRequest;
            prev_border <= borderColAudioRequest;
        end
    end

    // FSM, sound selection, note index, timers and tone output register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            snd      <= SND_BORDER;
            note_idx <= 2'd0;
            presc    <= '0;
            ms_cnt   <= 8'd0;
            tone_q   <= 4'd0;
        end else begin
            state    <= state_n;
            snd      <= snd_n;
            note_idx <= note_idx_n;
            presc    <= presc_n;
            ms_cnt   <= ms_cnt_n;
            tone_q   <= tone_n;
        end
    end

    // Next-state logic: trigger arbitration, preemption and note/gap timing.
    always_comb begin
        rise_key    = keyAudioRequest & ~prev_key;
        rise_hole   = holeColAudioRequest & ~prev_hole;
        rise_border = borderColAudioRequest & ~prev_border;
        trig_valid  = rise_key | rise_hole | rise_border;
        trig_snd    = rise_key ? SND_KEY : (rise_hole ? SND_HOLE : SND_BORDER);
        preempt     = trig_valid && ((state == S_IDLE) || (trig_snd >= snd));
        tick        = (presc == PRESC_LAST);

        case (snd)
            SND_KEY:  note_lim = KEY_LIM;
            SND_HOLE: note_lim = HOLE_LIM;
            default:  note_lim = BORDER_LIM;
        endcase
        last_idx = (snd == SND_HOLE) ? 2'd2 : 2'd0;

        state_n    = state;
        snd_n      = snd;
        note_idx_n = note_idx;
        presc_n    = tick ? '0 : presc + 1'b1;
        ms_cnt_n   = tick ? ms_cnt + 8'd1 : ms_cnt;
        tone_n     = tone_q;

        if (preempt) begin
            state_n    = S_NOTE;
            snd_n      = trig_snd;
            note_idx_n = 2'd0;
            presc_n    = '0;
            ms_cnt_n   = 8'd0;
            tone_n     = tone_of(trig_snd, 2'd0);
        end else begin
            case (state)
                S_NOTE: begin
                    if (tick && ms_cnt == note_lim) begin
                        state_n  = S_GAP;
                        presc_n  = '0;
                        ms_cnt_n = 8'd0;
                    end
                end
                S_GAP: begin
                    if (tick && ms_cnt == GAP_LIM) begin
                        presc_n  = '0;
                        ms_cnt_n = 8'd0;
                        if (note_idx != last_idx) begin
                            state_n    = S_NOTE;
                            note_idx_n = note_idx + 2'd1;
                            tone_n     = tone_of(snd, note_idx + 2'd1);
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                end
                default: begin
                    presc_n  = '0;
                    ms_cnt_n = 8'd0;
                end
            endcase
        end
    end

    assign enableSound = (state == S_NOTE);
    assign busy        = (state != S_IDLE);
    assign toneIndex   = tone_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer with MS_DIV=4: 1 ms = 4 cycles, so key note 160,
// hole notes 320, border note 80, every gap 40 cycles.
module tb_sound_sequencer;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetN;
    logic       key, hole, border;
    logic       en;
    logic [3:0] tone;
    logic       busy;
    logic [1:0] state_dbg;

    sound_sequencer #(.MS_DIV(4)) dut (
        .clk                   (clk),
        .resetN                (resetN),
        .keyAudioRequest       (key),
        .holeColAudioRequest   (hole),
        .borderColAudioRequest (border),
        .enableSound           (en),
        .toneIndex             (tone),
        .busy                  (busy),
        .state_dbg             (state_dbg)
    );

    typedef struct {
        string      name;
        logic       k;
        logic       h;
        logic       b;
        logic       en;
        logic [3:0] tone;
        logic       busy;
        int         n;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    string      cur_name;

    function automatic void add(input string name, input logic k, input logic h,
                                input logic b, input logic e, input logic [3:0] t,
                                input logic bz, input int n);
        vec_t v;
        v.name = name; v.k = k; v.h = h; v.b = b;
        v.en = e; v.tone = t; v.busy = bz; v.n = n;
        vecs.push_back(v);
    endfunction

    // scoreboard compare
    task automatic check_now(input string what, input logic [5:0] got, input logic [5:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @%0t: got en=%0b tone=%0d busy=%0b, want en=%0b tone=%0d busy=%0b",
                     what, $time, got[5], got[4:1], got[0], want[5], want[4:1], want[0]);
        end
    endtask

    // one clock: outputs sampled 1 time unit after the edge
    task automatic step();
        logic [5:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty at %0t", cur_name, $time);
        end else begin
            e = exp_q.pop_front();
            check_now(cur_name, {en, tone, busy}, e);
        end
    endtask

    // driver: expect a fixed output for n cycles
    task automatic expect_steps(input logic e, input logic [3:0] t, input logic bz, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({e, t, bz});
            step();
        end
    endtask

    task automatic run_vec(input vec_t v);
        cur_name = v.name;
        key      = v.k;
        hole     = v.h;
        border   = v.b;
        expect_steps(v.en, v.tone, v.busy, v.n);
    endtask

    initial begin
        resetN = 1'b0;
        key    = 1'b0;
        hole   = 1'b0;
        border = 1'b0;

        //   name               k  h  b  en tone busy cycles
        add("idle0",            0, 0, 0, 0, 0, 0, 5);
        // single-cycle key pulse
        add("key_rise",         1, 0, 0, 1, 9, 1, 1);
        add("key_note",         0, 0, 0, 1, 9, 1, 159);
        add("key_gap",          0, 0, 0, 0, 9, 1, 40);
        add("key_idle",         0, 0, 0, 0, 9, 0, 5);
        // hole held 2000 cycles: one arpeggio only
        add("hole_n0",          0, 1, 0, 1, 0, 1, 320);
        add("hole_g0",          0, 1, 0, 0, 0, 1, 40);
        add("hole_n1",          0, 1, 0, 1, 4, 1, 320);
        add("hole_g1",          0, 1, 0, 0, 4, 1, 40);
        add("hole_n2",          0, 1, 0, 1, 7, 1, 320);
        add("hole_g2",          0, 1, 0, 0, 7, 1, 40);
        add("hole_held_idle",   0, 1, 0, 0, 7, 0, 920);
        add("hole_release",     0, 0, 0, 0, 7, 0, 5);
        // border alone
        add("border_rise",      0, 0, 1, 1, 2, 1, 1);
        add("border_note",      0, 0, 0, 1, 2, 1, 79);
        add("border_gap",       0, 0, 0, 0, 2, 1, 40);
        add("border_idle",      0, 0, 0, 0, 2, 0, 5);
        // border preempted by key at cycle 50
        add("bk_border_rise",   0, 0, 1, 1, 2, 1, 1);
        add("bk_border_play",   0, 0, 0, 1, 2, 1, 49);
        add("bk_key_preempt",   1, 0, 0, 1, 9, 1, 1);
        add("bk_key_note",      0, 0, 0, 1, 9, 1, 159);
        add("bk_key_gap",       0, 0, 0, 0, 9, 1, 40);
        add("bk_idle",          0, 0, 0, 0, 9, 0, 5);
        // border during hole note 1 is ignored
        add("hb_hole_rise",     0, 1, 0, 1, 0, 1, 1);
        add("hb_n0",            0, 0, 0, 1, 0, 1, 319);
        add("hb_g0",            0, 0, 0, 0, 0, 1, 40);
        add("hb_n1_a",          0, 0, 0, 1, 4, 1, 100);
        add("hb_border_ignored",0, 0, 1, 1, 4, 1, 1);
        add("hb_n1_b",          0, 0, 0, 1, 4, 1, 219);
        add("hb_g1",            0, 0, 0, 0, 4, 1, 40);
        add("hb_n2",            0, 0, 0, 1, 7, 1, 320);
        add("hb_g2",            0, 0, 0, 0, 7, 1, 40);
        add("hb_idle",          0, 0, 0, 0, 7, 0, 5);
        // key and border in the same cycle
        add("kb_rise",          1, 0, 1, 1, 9, 1, 1);
        add("kb_note",          0, 0, 0, 1, 9, 1, 159);
        add("kb_gap",           0, 0, 0, 0, 9, 1, 40);
        add("kb_idle",          0, 0, 0, 0, 9, 0, 5);
        // key retriggered mid-note restarts from note 0
        add("kk_rise",          1, 0, 0, 1, 9, 1, 1);
        add("kk_note_a",        0, 0, 0, 1, 9, 1, 59);
        add("kk_retrigger",     1, 0, 0, 1, 9, 1, 1);
        add("kk_note_b",        0, 0, 0, 1, 9, 1, 159);
        add("kk_gap",           0, 0, 0, 0, 9, 1, 40);
        add("kk_idle",          0, 0, 0, 0, 9, 0, 5);
        // hole preempted by key; hole does not resume
        add("hk_hole_rise",     0, 1, 0, 1, 0, 1, 1);
        add("hk_hole_play",     0, 0, 0, 1, 0, 1, 50);
        add("hk_key_preempt",   1, 0, 0, 1, 9, 1, 1);
        add("hk_key_note",      0, 0, 0, 1, 9, 1, 159);
        add("hk_key_gap",       0, 0, 0, 0, 9, 1, 40);
        add("hk_idle",          0, 0, 0, 0, 9, 0, 5);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_state", {en, tone, busy}, 6'b0);
        resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // asynchronous reset in the middle of hole note 1
        cur_name = "rst_hole_rise";
        hole = 1'b1;
        expect_steps(1'b1, 4'd0, 1'b1, 1);
        cur_name = "rst_hole_play";
        hole = 1'b0;
        expect_steps(1'b1, 4'd0, 1'b1, 319);
        expect_steps(1'b0, 4'd0, 1'b1, 40);
        expect_steps(1'b1, 4'd4, 1'b1, 50);
        #2;
        resetN = 1'b0;
        #1;
        check_now("async_reset_immediate", {en, tone, busy}, 6'b0);
        @(posedge clk);
        #1;
        check_now("async_reset_held", {en, tone, busy}, 6'b0);
        resetN = 1'b1;
        cur_name = "post_reset_idle";
        expect_steps(1'b0, 4'd0, 1'b0, 20);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Sits directly downstream of the audio request mux. Consumes its three one-hot level request lines: key, hole collision, border collision.
- Converts each request rising edge into a timed tone sequence of 1–3 notes with silent gaps.
- Drives tone index and enable to the board tone generator (ToneDecoder / audio codec path).
- Higher-priority sounds preempt lower-priority ones in flight.

Parameters:
- MS_DIV, 31500, clk cycles per 1 ms tick (31.5 MHz clk); bench uses 4.
- KEY_MS, 40, duration of the single key-click note in ms.
- HOLE_NOTE_MS, 80, duration of each of the 3 hole notes in ms.
- BORDER_MS, 20, duration of the single border-hit note in ms.
- GAP_MS, 10, silence after every note in ms.
- KEY_TONE, 9, tone index for the key note.
- HOLE_TONE0/1/2, 0/4/7, tone indices of the ascending hole arpeggio.
- BORDER_TONE, 2, tone index for the border note.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- keyAudioRequest  in  1  level request from mux, priority 2 (highest)
- holeColAudioRequest  in  1  level request, priority 1
- borderColAudioRequest  in  1  level request, priority 0 (lowest)
- enableSound  out  1  1 = tone generator plays toneIndex
- toneIndex  out  4  note selector for tone generator
- busy  out  1  1 whenever the FSM is not IDLE (NOTE or GAP)

Behaviour:
- Reset (async, resetN=0): enableSound=0, toneIndex=0, busy=0, FSM=IDLE, edge registers=0, all counters=0. Applies immediately, including mid-sequence; no sound resumes after release.
- Edge detect: per input, prev register; rise = req & ~prev. Held levels never retrigger. A new trigger needs a low cycle first.
- Trigger selection: among rises in the same cycle, pick the highest priority (key > hole > border). Lower simultaneous rises are dropped, not queued.
- Preemption rule for a selected trigger:
  - FSM IDLE: start.
  - Trigger priority >= current sound priority: restart with the new sound; equal priority restarts the same sound from note 0.
  - Trigger priority < current sound priority: ignore.
- Latency: the edge where a rise is first sampled loads the sequence. enableSound=1 and toneIndex=note0 from the next cycle, i.e. 1 cycle after the request is seen high.
- FSM states:
  - IDLE → NOTE on start.
  - NOTE → GAP after NOTE_MS ticks.
  - GAP → NOTE(next note) after GAP_MS ticks if notes remain, else → IDLE.
  - Preempt from any state → NOTE with note 0 of the new sound.
- Timing:
  - ms prescaler counts 0..MS_DIV-1; tick on MS_DIV-1.
  - Prescaler and ms counter clear on every state entry and on preempt.
  - Each NOTE therefore lasts exactly NOTE_MS*MS_DIV cycles; each GAP lasts exactly GAP_MS*MS_DIV cycles.
  - ms counter is 8 bits; all ms parameters must be ≤ 255, checked by an elaboration assertion.
- Outputs in each state:
  - NOTE: enableSound=1, toneIndex=current note.
  - GAP and IDLE: enableSound=0, toneIndex holds its last value.
  - busy=1 in NOTE and GAP.
- Note counts: key 1, hole 3 (2-bit note index), border 1.
- Total sequence lengths:
  - key = (40+10) ms
  - hole = 3×(80+10) ms
  - border = (20+10) ms
- Outputs are registered; no combinational path from the request inputs to the outputs.

Test Plan:
(MS_DIV=4, default ms values)
- Reset, then a single-cycle keyAudioRequest pulse → enableSound=1, toneIndex=9 one cycle later for 160 cycles; then 40 cycles of enableSound=0; then busy=0.
- holeColAudioRequest held high for 2000 cycles → tones 0, 4, 7, each 320 cycles, separated by 40-cycle gaps. Exactly one sequence plays; no retrigger while held.
- Border playing, key rise at cycle 50 → toneIndex=9 the next cycle and the key note runs a full 160 cycles; border does not resume.
- Hole playing (note 1), border rise → ignored; hole sequence completes unchanged.
- Key and border rise in the same cycle → only the key sound plays; border is dropped and idle follows the key sequence.
- resetN asserted low mid-hole note → enableSound, busy, toneIndex=0 immediately. After release with no new rise, outputs stay idle.
